// File: rtl/winograd_pkg.sv
// Shared definitions for the Winograd F(2x2,3x3) tile scheduler: FSM states,
// tile geometry constants and the nominal datapath latency.
package winograd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        LOAD_FILT,
        RUN,
        DRAIN,
        DONE
    } wino_state_e;

    localparam int TILE_IN  = 4;
    localparam int TILE_OUT = 2;
    localparam int STRIDE   = 2;
    localparam int MIN_DIM  = 4;

    localparam int WINO_LAT = 4;

endpackage

// File: rtl/winograd_valid_pipe.sv
// Fixed-depth {valid, addr} delay line mirroring the no-stall datapath so each
// accepted tile's output address emerges exactly DEPTH cycles later.
module winograd_valid_pipe #(
    parameter int DEPTH  = 5,
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              vld_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              vld_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              any_vld_o
);

    logic [DEPTH-1:0]  vld_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            vld_q <= {vld_q[DEPTH-2:0], vld_i};
            // Empty slots carry a zero address so wr_addr idles at 0.
            addr_q[0] <= vld_i ? addr_i : '0;
            for (int i = 1; i < DEPTH; i++) begin
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign vld_o     = vld_q[DEPTH-1];
    assign addr_o    = addr_q[DEPTH-1];
    assign any_vld_o = |vld_q;

endmodule

// File: rtl/winograd_tile_sched.sv
// Winograd F(2x2,3x3) tile scheduler: filter load, stride-2 tile walk, latency tracking.
// Optional performance counters are built when WINO_PERF_CNT_EN is defined.
module winograd_tile_sched
    import winograd_pkg::*;
#(
    parameter int LAT    = WINO_LAT,
    parameter int DIM_W  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_rows,
    input  logic [DIM_W-1:0]  cfg_cols,
    output logic              filt_load,
    output logic              rd_req,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef WINO_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stalls
`endif
);

    wino_state_e       state_q;
    logic [DIM_W-1:0]  rows_q;
    logic [DIM_W-1:0]  cols_q;
    logic [DIM_W-1:0]  tc_q;
    logic [DIM_W-1:0]  tr_q;
    logic [DIM_W-1:0]  tpr_last_q;
    logic [DIM_W-1:0]  tpc_last_q;
    logic [ADDR_W-1:0] row_base_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] wr_idx_q;
    logic              filt_load_q;
    logic              rd_req_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              accept;
    logic              last_tc;
    logic              last_tile;
    logic              cfg_bad;
    logic [ADDR_W-1:0] row_step;
    logic [ADDR_W-1:0] row_base_d;
    logic              pipe_busy;

    assign accept    = rd_req_q & rd_ready;
    assign last_tc   = (tc_q == tpr_last_q);
    assign last_tile = last_tc && (tr_q == tpc_last_q);
    assign cfg_bad   = (rows_q < DIM_W'(MIN_DIM)) || rows_q[0] ||
                       (cols_q < DIM_W'(MIN_DIM)) || cols_q[0];
    // One tile row down is STRIDE pixel rows of the input map.
    assign row_step   = ADDR_W'({cols_q, 1'b0});
    assign row_base_d = row_base_q + row_step;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rows_q      <= '0;
            cols_q      <= '0;
            tc_q        <= '0;
            tr_q        <= '0;
            tpr_last_q  <= '0;
            tpc_last_q  <= '0;
            row_base_q  <= '0;
            rd_addr_q   <= '0;
            wr_idx_q    <= '0;
            filt_load_q <= 1'b0;
            rd_req_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            filt_load_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rows_q  <= cfg_rows;
                        cols_q  <= cfg_cols;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (cfg_bad) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        // Store last tile indices: tiles per row/col minus one.
                        tpr_last_q  <= (cols_q >> 1) - DIM_W'(2);
                        tpc_last_q  <= (rows_q >> 1) - DIM_W'(2);
                        tc_q        <= '0;
                        tr_q        <= '0;
                        row_base_q  <= '0;
                        rd_addr_q   <= '0;
                        wr_idx_q    <= '0;
                        filt_load_q <= 1'b1;
                        state_q     <= LOAD_FILT;
                    end
                end
                LOAD_FILT: begin
                    rd_req_q <= 1'b1;
                    state_q  <= RUN;
                end
                RUN: begin
                    if (accept) begin
                        wr_idx_q <= wr_idx_q + ADDR_W'(1);
                        if (last_tile) begin
                            rd_req_q <= 1'b0;
                            state_q  <= DRAIN;
                        end else if (last_tc) begin
                            tc_q       <= '0;
                            tr_q       <= tr_q + DIM_W'(1);
                            row_base_q <= row_base_d;
                            rd_addr_q  <= row_base_d;
                        end else begin
                            tc_q      <= tc_q + DIM_W'(1);
                            rd_addr_q <= rd_addr_q + ADDR_W'(STRIDE);
                        end
                    end
                end
                DRAIN: begin
                    if (!pipe_busy) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    winograd_valid_pipe #(
        .DEPTH  (LAT + 1),
        .ADDR_W (ADDR_W)
    ) u_valid_pipe (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .vld_i     (accept),
        .addr_i    (wr_idx_q),
        .vld_o     (wr_valid),
        .addr_o    (wr_addr),
        .any_vld_o (pipe_busy)
    );

    assign filt_load = filt_load_q;
    assign rd_req    = rd_req_q;
    assign rd_addr   = rd_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

`ifdef WINO_PERF_CNT_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_stalls_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else if (state_q == IDLE && start) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (busy_q) begin
                perf_cycles_q <= sat_inc(perf_cycles_q);
            end
            if (state_q == RUN && !rd_ready) begin
                perf_stalls_q <= sat_inc(perf_stalls_q);
            end
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_winograd_tile_sched.sv
// Scoreboard bench for winograd_tile_sched; optional counters checked when
// WINO_PERF_CNT_EN is defined.
module tb_winograd_tile_sched;

    localparam int LAT    = 4;
    localparam int DIM_W  = 8;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic [DIM_W-1:0]  cfg_rows = '0;
    logic [DIM_W-1:0]  cfg_cols = '0;
    logic              rd_ready = 1'b1;
    logic              filt_load;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic              busy;
    logic              done;
    logic              err;
`ifdef WINO_PERF_CNT_EN
    logic [31:0]       perf_cycles;
    logic [31:0]       perf_stalls;
`endif

    winograd_tile_sched #(
        .LAT    (LAT),
        .DIM_W  (DIM_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .cfg_rows  (cfg_rows),
        .cfg_cols  (cfg_cols),
        .filt_load (filt_load),
        .rd_req    (rd_req),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef WINO_PERF_CNT_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_stalls (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int exp_rd[$];
    int exp_wr[$];
    int acc_q[$];

    int filt_cnt, done_cnt, wr_cnt, stall_cnt, busy_cnt, layer_acc;
    int filt_cyc, first_rd_cyc, done_cyc, last_wr_cyc;
    int s_cyc, n_tiles;
    bit bad_cfg;
    bit prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    int mode = 0;
    int stall_left = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected reads/writes as the DUT presents them.
    always @(negedge clk) begin
        if (rstn) begin
            if (busy) busy_cnt++;
            if (filt_load) begin
                filt_cnt++;
                if (filt_cyc < 0) filt_cyc = cyc;
            end
            if (rd_req) begin
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                if (prev_stall) chk("rd_addr_hold", rd_addr, prev_addr);
                if (!rd_ready) stall_cnt++;
                else begin
                    if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
                    else chk("rd_addr", rd_addr, exp_rd.pop_front());
                    acc_q.push_back(cyc);
                    layer_acc++;
                end
            end
            prev_stall = rd_req && !rd_ready;
            prev_addr  = rd_addr;
            if (wr_valid) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
                else chk("wr_addr", wr_addr, exp_wr.pop_front());
                if (acc_q.size() == 0) chk("wr_no_accept", 1, 0);
                else chk("wr_latency", cyc - acc_q.pop_front(), LAT + 1);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // rd_ready driver: always ready, random, or a 3-cycle stall on the second tile.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                1: rd_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (rd_req && layer_acc == 1 && stall_left > 0) begin
                        rd_ready = 1'b0;
                        stall_left--;
                    end else begin
                        rd_ready = 1'b1;
                    end
                end
                default: rd_ready = 1'b1;
            endcase
        end
    end

    task automatic start_layer(input int rows, input int cols, input int m);
        int tpr, tpc;
        bad_cfg = (rows < 4) || (cols < 4) || (rows % 2 != 0) || (cols % 2 != 0);
        exp_rd.delete();
        exp_wr.delete();
        acc_q.delete();
        if (!bad_cfg) begin
            tpr = (cols - 2) / 2;
            tpc = (rows - 2) / 2;
            for (int r = 0; r < tpc; r++) begin
                for (int c = 0; c < tpr; c++) begin
                    exp_rd.push_back(2 * r * cols + 2 * c);
                    exp_wr.push_back(r * tpr + c);
                end
            end
        end
        n_tiles = exp_wr.size();
        filt_cnt = 0; done_cnt = 0; wr_cnt = 0; stall_cnt = 0; busy_cnt = 0;
        layer_acc = 0; filt_cyc = -1; first_rd_cyc = -1; done_cyc = -1; last_wr_cyc = -1;
        stall_left = 3;
        mode = m;
        @(posedge clk);
        #1;
        cfg_rows = DIM_W'(rows);
        cfg_cols = DIM_W'(cols);
        start = 1'b1;
        s_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg_rows = DIM_W'($urandom);
        cfg_cols = DIM_W'($urandom);
    endtask

    task automatic finish_layer();
        int t;
        t = 0;
        while (done_cnt == 0 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (done_cnt == 0) begin
            chk("done_timeout", 0, 1);
            return;
        end
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("err", err, bad_cfg);
        chk("filt_load_count", filt_cnt, bad_cfg ? 0 : 1);
        chk("wr_count", wr_cnt, n_tiles);
        chk("rd_left", exp_rd.size(), 0);
        if (bad_cfg) begin
            chk("err_done_latency", done_cyc - s_cyc, 2);
        end else begin
            chk("filt_load_latency", filt_cyc - s_cyc, 2);
            chk("first_rd_latency", first_rd_cyc - s_cyc, 3);
            chk("done_after_last_wr", done_cyc - last_wr_cyc, 2);
        end
`ifdef WINO_PERF_CNT_EN
        chk("perf_cycles", perf_cycles, busy_cnt);
        chk("perf_stalls", perf_stalls, stall_cnt);
`endif
        repeat (3) @(negedge clk);
        chk("done_count", done_cnt, 1);
        mode = 0;
    endtask

    task automatic run_layer(input int rows, input int cols, input int m, input bit restart);
        int t;
        start_layer(rows, cols, m);
        if (restart) begin
            t = 0;
            while (!rd_req && t < 50) begin
                @(posedge clk);
                #1;
                t++;
            end
            chk("restart_reached_run", rd_req, 1);
            cfg_rows = 8'd4;
            cfg_cols = 8'd4;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        finish_layer();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_filt_load"}, filt_load, 0);
        chk({tag, "_rd_req"}, rd_req, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_wr_valid"}, wr_valid, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        int t, wr_snap, done_snap, rr, cc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk_outputs_zero("post_reset");

        run_layer(4, 4, 0, 0);
        run_layer(6, 6, 0, 0);
        run_layer(6, 8, 2, 0);
        chk("stall_cycles_seen", stall_cnt, 3);
        run_layer(5, 6, 0, 0);
        run_layer(2, 8, 0, 0);
        run_layer(4, 4, 0, 0);
        run_layer(6, 6, 0, 1);

        // Abort a layer with reset while it is issuing tiles.
        start_layer(8, 8, 0);
        t = 0;
        while (!rd_req && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(negedge clk);
        chk_outputs_zero("abort_reset");
        @(posedge clk);
        #1;
        exp_rd.delete();
        exp_wr.delete();
        acc_q.delete();
        prev_stall = 1'b0;
        wr_snap = wr_cnt;
        done_snap = done_cnt;
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_wr", wr_cnt, wr_snap);
        chk("abort_no_done", done_cnt, done_snap);
        chk("abort_idle_busy", busy, 0);
        run_layer(4, 4, 0, 0);

        for (int i = 0; i < 6; i++) begin
            rr = 2 * $urandom_range(2, 7);
            cc = 2 * $urandom_range(2, 7);
            if (i == 5) rr = rr + 1;
            run_layer(rr, cc, 1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
